opcode_fetch: RTL and testbench
===============================

Name: opcode_fetch

Overview:
- Front-end byte fetcher for the 6809 core.
- Reads the opcode byte from memory, follows a page-2 (0x10) or page-3 (0x11) prefix to fetch the postbyte0 opcode, and fetches the register/immediate postbyte or indexed EA postbyte when the opcode needs one.
- Presents {opcode, postbyte0, page2_valid, page3_valid, eapostbyte} to the register/op/ALU decoders and the sequencer through a valid/ready handshake.
- Offsets, immediates and extended addresses are not fetched here; the sequencer fetches them starting at pc_next.

Parameters:
RESET_PC, 16'hFFFE, fetch address loaded by reset
TIMEOUT_CYCLES, 8'd255, wait-for-ack cycles before bus_err; 0 disables timeout

Ports:
cpu_clk  in  1  clock, all state on rising edge
cpu_reset  in  1  synchronous, active-high reset
fetch_start  in  1  begin a new fetch at fetch_pc; overrides every state
fetch_pc  in  16  start address, sampled with fetch_start
mem_addr  out  16  byte read address
mem_rd  out  1  read request, held until mem_ack
mem_data  in  8  read data, valid in the mem_ack cycle
mem_ack  in  1  read completion
instr_valid  out  1  decoded-byte bundle valid
instr_ready  in  1  consumer accepts bundle
opcode  out  8  page-1 opcode; 0x10/0x11 when prefixed
postbyte0  out  8  page-2/3 opcode, or TFR/EXG/PSH/PUL/ORCC/ANDCC/CWAI postbyte
page2_valid  out  1  postbyte0 is a page-2 opcode
page3_valid  out  1  postbyte0 is a page-3 opcode
eapostbyte  out  8  indexed-mode EA postbyte
ea_valid  out  1  eapostbyte was fetched for this instruction
pc_next  out  16  address after the last fetched byte
bus_err  out  1  one-cycle pulse on ack timeout
illegal  out  1  undefined opcode flag (OPFETCH_ILLEGAL_EN only)

Behaviour:
- Reset: state IDLE, pc=RESET_PC, mem_rd=0, mem_addr=RESET_PC, instr_valid=0.
- Reset: opcode, postbyte0 and eapostbyte = 8'h00; page2_valid, page3_valid, ea_valid, bus_err and illegal = 0; pc_next=RESET_PC.
- Reset is taken in any state and drops an outstanding request with no data captured.
- States: IDLE, F_OP, F_PB, F_EA, HOLD.
- IDLE: outputs retain the last bundle and instr_valid=0. Leaves IDLE only on fetch_start.
- fetch_start in any state: pc<=fetch_pc and state<=F_OP next cycle.
  - Page and ea flags clear.
  - An ack arriving in that same cycle is discarded.
- Fetch states: mem_rd=1 and mem_addr=pc.
  - On mem_ack: capture mem_data, pc<=pc+1 (wraps 16'hFFFF->16'h0000).
  - mem_rd drops for exactly one cycle after each ack.
- F_OP with data d:
  - d=0x10 or 0x11: opcode<=d, go F_PB.
  - d in 0x1A,0x1C,0x1E,0x1F,0x34..0x37,0x3C: opcode<=d, go F_PB as a non-page postbyte.
  - d in 0x30..0x33,0x6x,0xAx,0xEx: opcode<=d, go F_EA.
  - Otherwise: opcode<=d, go HOLD.
- F_PB after prefix 0x10/0x11:
  - Data 0x10/0x11 (repeated prefix): opcode<=data, stay in F_PB; the latest prefix wins.
  - Other data: postbyte0<=data; page2_valid=(opcode==0x10), page3_valid=(opcode==0x11).
  - Data in 0xAx/0xEx goes F_EA, else HOLD.
- F_PB for a non-page postbyte: postbyte0<=data, go HOLD.
- F_EA: eapostbyte<=data, ea_valid<=1, go HOLD.
- HOLD: instr_valid=1, all bundle outputs stable, pc_next=pc.
  - instr_valid&instr_ready: go IDLE next cycle.
  - fetch_start in the same cycle as ready: fetch_start wins, go F_OP.
- Minimum latency, ack in the same cycle as request: 1 byte fetched -> instr_valid 2 cycles after fetch_start.
- Timeout: counter counts cycles with mem_rd=1 and mem_ack=0, clearing on ack or fetch_start.
  - Reaching TIMEOUT_CYCLES: bus_err=1 for one cycle, state<=IDLE, mem_rd=0.

Optional Feature:
- Macro OPFETCH_ILLEGAL_EN.
- Defined: in HOLD, illegal=1 when the final opcode is undefined:
  - page 1: 0x01,0x02,0x05,0x0B,0x14,0x15,0x18,0x1B,0x38,0x3E,0x41,0x42,0x45,0x4B,0x4E,0x51,0x52,0x55,0x5B,0x5E,0x61,0x62,0x65,0x6B,0x71,0x72,0x75,0x7B,0x87,0x8F,0xC7,0xCD,0xCF;
  - postbyte0 with page2_valid: anything outside 0x21..0x2F,0x3F,0x83,0x8C,0x8E,0x93,0x9C,0x9E,0x9F,0xA3,0xAC,0xAE,0xAF,0xB3,0xBC,0xBE,0xBF,0xCE,0xDE,0xDF,0xEE,0xEF,0xFE,0xFF;
  - postbyte0 with page3_valid: anything outside 0x3F,0x83,0x8C,0x93,0x9C,0xA3,0xAC,0xB3,0xBC.
- illegal is 0 outside HOLD.
- Not defined: the illegal port exists and is tied to 0, with no decode logic.

Test Plan:
- fetch_start, fetch_pc=0x1000, mem holds 0x86, ack every request -> HOLD with opcode=0x86, page flags 0, ea_valid=0, pc_next=0x1001, instr_valid high until ready.
- mem 0x10,0xAE,0x84 at 0x2000 -> opcode=0x10, postbyte0=0xAE, page2_valid=1, eapostbyte=0x84, ea_valid=1, pc_next=0x2003.
- mem 0x11,0x10,0x11,0x83 -> opcode=0x11, postbyte0=0x83, page3_valid=1, page2_valid=0, pc_next=start+4.
- mem 0x1F,0x89 at 0xFFFF -> postbyte0=0x89, page flags 0; second read at 0x0000, pc_next=0x0001.
- No mem_ack, TIMEOUT_CYCLES=4 -> bus_err pulses after 4 waiting cycles, mem_rd=0, IDLE.
- fetch_start mid-F_EA coinciding with ack; separately, cpu_reset in F_PB -> ack data discarded, refetch at the new fetch_pc; reset gives IDLE, pc_next=0xFFFE, instr_valid=0.

Source files
------------

// File: rtl/opcode_fetch.sv
// opcode_fetch: 6809 opcode/prefix/postbyte fetcher; clk cpu_clk, sync reset cpu_reset, fetch_start/fetch_pc restart, mem_* byte read bus, instr_* bundle handshake, bus_err on ack timeout, illegal decode under OPFETCH_ILLEGAL_EN
module opcode_fetch #(
  parameter logic [15:0] RESET_PC       = 16'hFFFE,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
  input  logic        cpu_clk,
  input  logic        cpu_reset,
  input  logic        fetch_start,
  input  logic [15:0] fetch_pc,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  input  logic        mem_ack,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  opcode,
  output logic [7:0]  postbyte0,
  output logic        page2_valid,
  output logic        page3_valid,
  output logic [7:0]  eapostbyte,
  output logic        ea_valid,
  output logic [15:0] pc_next,
  output logic        bus_err,
  output logic        illegal
);
  typedef enum logic [2:0] {IDLE, F_OP, F_PB, F_EA, HOLD} state_t;
  state_t state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0] opcode_q, opcode_d, pb_q, pb_d, ea_q, ea_d, tmo_q, tmo_d;
  logic p2_q, p2_d, p3_q, p3_d, eav_q, eav_d, gap_q, gap_d, err_q, err_d;
  logic take, waiting, timeout, is_pfx, is_pb, is_ea, is_pfx_op, ea_pb;
  assign mem_rd      = (state_q == F_OP || state_q == F_PB || state_q == F_EA) && !gap_q;
  assign mem_addr    = pc_q;
  assign pc_next     = pc_q;
  assign instr_valid = state_q == HOLD;
  assign opcode      = opcode_q;
  assign postbyte0   = pb_q;
  assign page2_valid = p2_q;
  assign page3_valid = p3_q;
  assign eapostbyte  = ea_q;
  assign ea_valid    = eav_q;
  assign bus_err     = err_q;
  always_comb begin
    take      = mem_rd && mem_ack && !fetch_start;
    waiting   = mem_rd && !mem_ack;
    timeout   = waiting && TIMEOUT_CYCLES != 8'd0 && tmo_q + 8'd1 == TIMEOUT_CYCLES;
    is_pfx    = mem_data == 8'h10 || mem_data == 8'h11;
    is_pb     = mem_data inside {8'h1A, 8'h1C, 8'h1E, 8'h1F, [8'h34:8'h37], 8'h3C};
    is_ea     = mem_data inside {[8'h30:8'h33]} || mem_data[7:4] inside {4'h6, 4'hA, 4'hE};
    ea_pb     = mem_data[7:4] inside {4'hA, 4'hE};
    is_pfx_op = opcode_q == 8'h10 || opcode_q == 8'h11;
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    pb_d      = pb_q;
    ea_d      = ea_q;
    p2_d      = p2_q;
    p3_d      = p3_q;
    eav_d     = eav_q;
    gap_d     = take;
    err_d     = 1'b0;
    tmo_d     = take ? 8'd0 : waiting ? tmo_q + 8'd1 : tmo_q;
    if (fetch_start) begin
      state_d = F_OP;
      pc_d    = fetch_pc;
      p2_d    = 1'b0;
      p3_d    = 1'b0;
      eav_d   = 1'b0;
      tmo_d   = 8'd0;
    end else if (timeout) begin
      state_d = IDLE;
      err_d   = 1'b1;
      tmo_d   = 8'd0;
    end else if (take) begin
      pc_d = pc_q + 16'd1;
      case (state_q)
        F_OP: begin
          opcode_d = mem_data;
          state_d  = (is_pfx || is_pb) ? F_PB : is_ea ? F_EA : HOLD;
        end
        F_PB: begin
          // a repeated prefix replaces the pending one; only the last counts
          if (is_pfx_op && is_pfx) opcode_d = mem_data;
          else begin
            pb_d    = mem_data;
            p2_d    = opcode_q == 8'h10;
            p3_d    = opcode_q == 8'h11;
            state_d = (is_pfx_op && ea_pb) ? F_EA : HOLD;
          end
        end
        F_EA: begin
          ea_d    = mem_data;
          eav_d   = 1'b1;
          state_d = HOLD;
        end
        default: state_d = state_q;
      endcase
    end else if (state_q == HOLD && instr_ready) state_d = IDLE;
  end
  always_ff @(posedge cpu_clk) begin
    if (cpu_reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      opcode_q <= 8'h00;
      pb_q     <= 8'h00;
      ea_q     <= 8'h00;
      tmo_q    <= 8'd0;
      p2_q     <= 1'b0;
      p3_q     <= 1'b0;
      eav_q    <= 1'b0;
      gap_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      pb_q     <= pb_d;
      ea_q     <= ea_d;
      tmo_q    <= tmo_d;
      p2_q     <= p2_d;
      p3_q     <= p3_d;
      eav_q    <= eav_d;
      gap_q    <= gap_d;
      err_q    <= err_d;
    end
  end
`ifdef OPFETCH_ILLEGAL_EN
  logic undef;
  always_comb
    undef = p2_q ? !(pb_q inside {[8'h21:8'h2F], 8'h3F, 8'h83, 8'h8C, 8'h8E, 8'h93, 8'h9C, 8'h9E, 8'h9F,
                                  8'hA3, 8'hAC, 8'hAE, 8'hAF, 8'hB3, 8'hBC, 8'hBE, 8'hBF, 8'hCE, 8'hDE,
                                  8'hDF, 8'hEE, 8'hEF, 8'hFE, 8'hFF})
          : p3_q ? !(pb_q inside {8'h3F, 8'h83, 8'h8C, 8'h93, 8'h9C, 8'hA3, 8'hAC, 8'hB3, 8'hBC})
          : opcode_q inside {8'h01, 8'h02, 8'h05, 8'h0B, 8'h14, 8'h15, 8'h18, 8'h1B, 8'h38, 8'h3E, 8'h41,
                             8'h42, 8'h45, 8'h4B, 8'h4E, 8'h51, 8'h52, 8'h55, 8'h5B, 8'h5E, 8'h61, 8'h62,
                             8'h65, 8'h6B, 8'h71, 8'h72, 8'h75, 8'h7B, 8'h87, 8'h8F, 8'hC7, 8'hCD, 8'hCF};
  assign illegal = state_q == HOLD && undef;
`else
  assign illegal = 1'b0;
`endif
endmodule

// File: tb/tb_opcode_fetch.sv
// tb_opcode_fetch: randomized bench for opcode_fetch against a byte-walking reference model
module tb_opcode_fetch;
  logic cpu_clk = 0, cpu_reset = 1, fetch_start = 0, mem_ack = 0, instr_ready = 0;
  logic [15:0] fetch_pc = 0, mem_addr, pc_next;
  logic [7:0] mem_data = 0, opcode, postbyte0, eapostbyte;
  logic mem_rd, instr_valid, page2_valid, page3_valid, ea_valid, bus_err, illegal;
  opcode_fetch #(.RESET_PC(16'hFFFE), .TIMEOUT_CYCLES(8'd4)) dut (
    .cpu_clk(cpu_clk), .cpu_reset(cpu_reset), .fetch_start(fetch_start), .fetch_pc(fetch_pc),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ack(mem_ack),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .opcode(opcode), .postbyte0(postbyte0),
    .page2_valid(page2_valid), .page3_valid(page3_valid), .eapostbyte(eapostbyte), .ea_valid(ea_valid),
    .pc_next(pc_next), .bus_err(bus_err), .illegal(illegal));
  always #5 cpu_clk = ~cpu_clk;
  int checks = 0, failures = 0;
  logic [7:0] mem [65536];
  bit auto_ack = 0;
  int dly = 0, max_dly = 0;
  logic [15:0] last_addr = 0;
  logic [7:0] e_op = 0, e_pb = 0, e_ea = 0;
  logic e_p2 = 0, e_p3 = 0, e_eav = 0;
  logic [15:0] e_pcn = 16'hFFFE;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(negedge cpu_clk)
    if (auto_ack) begin
      mem_ack = 0;
      if (mem_rd) begin
        if (dly == 0) begin
          mem_ack = 1;
          mem_data = mem[mem_addr];
          last_addr = mem_addr;
          dly = $urandom_range(max_dly, 0);
        end else dly--;
      end
    end
`ifdef OPFETCH_ILLEGAL_EN
  function automatic logic ref_illegal();
    if (e_p2) return !(e_pb inside {[8'h21:8'h2F], 8'h3F, 8'h83, 8'h8C, 8'h8E, 8'h93, 8'h9C, 8'h9E, 8'h9F,
      8'hA3, 8'hAC, 8'hAE, 8'hAF, 8'hB3, 8'hBC, 8'hBE, 8'hBF, 8'hCE, 8'hDE, 8'hDF, 8'hEE, 8'hEF, 8'hFE, 8'hFF});
    if (e_p3) return !(e_pb inside {8'h3F, 8'h83, 8'h8C, 8'h93, 8'h9C, 8'hA3, 8'hAC, 8'hB3, 8'hBC});
    return e_op inside {8'h01, 8'h02, 8'h05, 8'h0B, 8'h14, 8'h15, 8'h18, 8'h1B, 8'h38, 8'h3E, 8'h41, 8'h42,
      8'h45, 8'h4B, 8'h4E, 8'h51, 8'h52, 8'h55, 8'h5B, 8'h5E, 8'h61, 8'h62, 8'h65, 8'h6B, 8'h71, 8'h72,
      8'h75, 8'h7B, 8'h87, 8'h8F, 8'hC7, 8'hCD, 8'hCF};
  endfunction
`else
  function automatic logic ref_illegal();
    return 1'b0;
  endfunction
`endif
  // Walk the instruction bytes in memory from pc and predict the bundle.
  task automatic model(input logic [15:0] pc);
    logic [15:0] p;
    p = pc;
    e_p2 = 0; e_p3 = 0; e_eav = 0;
    e_op = mem[p]; p++;
    if (e_op == 8'h10 || e_op == 8'h11) begin
      while (mem[p] == 8'h10 || mem[p] == 8'h11) begin e_op = mem[p]; p++; end
      e_pb = mem[p]; p++;
      e_p2 = e_op == 8'h10; e_p3 = e_op == 8'h11;
      if (e_pb[7:4] == 4'hA || e_pb[7:4] == 4'hE) begin e_ea = mem[p]; p++; e_eav = 1; end
    end else if (e_op inside {8'h1A, 8'h1C, 8'h1E, 8'h1F, 8'h34, 8'h35, 8'h36, 8'h37, 8'h3C}) begin
      e_pb = mem[p]; p++;
    end else if ((e_op >= 8'h30 && e_op <= 8'h33) || e_op[7:4] == 4'h6 || e_op[7:4] == 4'hA || e_op[7:4] == 4'hE) begin
      e_ea = mem[p]; p++; e_eav = 1;
    end
    e_pcn = p;
  endtask
  task automatic start(input logic [15:0] pc);
    @(negedge cpu_clk); fetch_start = 1; fetch_pc = pc;
    @(negedge cpu_clk); fetch_start = 0;
  endtask
  task automatic bundle_check();
    check("opcode", opcode, e_op);
    check("postbyte0", postbyte0, e_pb);
    check("eapostbyte", eapostbyte, e_ea);
    check("page2_valid", page2_valid, e_p2);
    check("page3_valid", page3_valid, e_p3);
    check("ea_valid", ea_valid, e_eav);
    check("pc_next", pc_next, e_pcn);
  endtask
  task automatic finish_check(input logic [15:0] pc);
    int n;
    model(pc);
    for (n = 0; n < 200 && !instr_valid; n++) @(negedge cpu_clk);
    check("instr_valid_wait", instr_valid, 1);
    bundle_check();
    check("illegal", illegal, ref_illegal());
    repeat ($urandom_range(3, 0)) @(negedge cpu_clk);
    check("valid_held", instr_valid, 1);
    check("opcode_held", opcode, e_op);
    instr_ready = 1;
    @(negedge cpu_clk); instr_ready = 0;
    check("valid_drop", instr_valid, 0);
    check("illegal_idle", illegal, 0);
  endtask
  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (2) @(negedge cpu_clk);
    check("rst_valid", instr_valid, 0);
    check("rst_rd", mem_rd, 0);
    check("rst_addr", mem_addr, 16'hFFFE);
    check("rst_err", bus_err, 0);
    bundle_check();
    cpu_reset = 0;
    // single-byte opcode with zero-wait acks: minimum latency
    mem[16'h1000] = 8'h86;
    auto_ack = 1; max_dly = 0; dly = 0;
    start(16'h1000);
    check("lat_rd", mem_rd, 1);
    check("lat_valid0", instr_valid, 0);
    @(negedge cpu_clk);
    check("lat_valid1", instr_valid, 1);
    finish_check(16'h1000);
    max_dly = 2;
    mem[16'h2000] = 8'h10; mem[16'h2001] = 8'hAE; mem[16'h2002] = 8'h84;
    start(16'h2000); finish_check(16'h2000);
    check("p2_pcn", pc_next, 16'h2003);
    mem[16'h2100] = 8'h11; mem[16'h2101] = 8'h10; mem[16'h2102] = 8'h11; mem[16'h2103] = 8'h83;
    start(16'h2100); finish_check(16'h2100);
    check("p3_flag", {opcode, postbyte0, page3_valid}, {8'h11, 8'h83, 1'b1});
    mem[16'hFFFF] = 8'h1F; mem[16'h0000] = 8'h89;
    start(16'hFFFF); finish_check(16'hFFFF);
    check("wrap_addr", last_addr, 16'h0000);
    check("wrap_pcn", pc_next, 16'h0001);
    // no acks: timeout after 4 waiting cycles
    auto_ack = 0; mem_ack = 0;
    start(16'h6000);
    check("to_rd", mem_rd, 1);
    for (n = 0; n < 20 && !bus_err; n++) @(negedge cpu_clk);
    check("to_cycles", n, 4);
    check("to_rd_off", mem_rd, 0);
    check("to_valid", instr_valid, 0);
    @(negedge cpu_clk);
    check("to_pulse", bus_err, 0);
    check("to_idle_rd", mem_rd, 0);
    // restart in F_EA coinciding with an ack
    mem[16'h3000] = 8'hA6;
    start(16'h3000);
    mem_ack = 1; mem_data = 8'hA6;
    @(negedge cpu_clk); mem_ack = 0;
    check("gap_rd", mem_rd, 0);
    @(negedge cpu_clk);
    check("ea_addr", mem_addr, 16'h3001);
    mem_ack = 1; mem_data = 8'h99; fetch_start = 1; fetch_pc = 16'h4000;
    @(negedge cpu_clk); mem_ack = 0; fetch_start = 0;
    check("fs_addr", mem_addr, 16'h4000);
    check("fs_rd", mem_rd, 1);
    check("fs_eav", ea_valid, 0);
    check("fs_ea_kept", eapostbyte, e_ea);
    mem[16'h4000] = 8'h12;
    dly = 0; auto_ack = 1;
    finish_check(16'h4000);
    // reset while in F_PB with an ack pending
    auto_ack = 0; mem_ack = 0;
    mem[16'h5000] = 8'h10;
    start(16'h5000);
    mem_ack = 1; mem_data = 8'h10;
    @(negedge cpu_clk); mem_ack = 0;
    @(negedge cpu_clk);
    check("pb_rd", mem_rd, 1);
    cpu_reset = 1; mem_ack = 1; mem_data = 8'h21;
    @(negedge cpu_clk); cpu_reset = 0; mem_ack = 0;
    e_op = 0; e_pb = 0; e_ea = 0; e_p2 = 0; e_p3 = 0; e_eav = 0; e_pcn = 16'hFFFE;
    check("rr_valid", instr_valid, 0);
    check("rr_rd", mem_rd, 0);
    check("rr_addr", mem_addr, 16'hFFFE);
    bundle_check();
    mem[16'h7000] = 8'h10; mem[16'h7001] = 8'h21;
    dly = 0; auto_ack = 1;
    start(16'h7000); finish_check(16'h7000);
    for (int k = 0; k < 40; k++) begin
      logic [15:0] pc;
      logic [7:0] firsts [12];
      firsts = '{8'h10, 8'h11, 8'h1F, 8'h34, 8'h6A, 8'hA6, 8'hE3, 8'h30, 8'h86, 8'h12, 8'h01, 8'h3C};
      pc = 16'($urandom);
      mem[pc] = ($urandom_range(3, 0) == 0) ? 8'($urandom) : firsts[$urandom_range(11, 0)];
      if ($urandom_range(3, 0) == 0) mem[16'(pc + 16'd1)] = 8'h10 + 8'($urandom_range(1, 0));
      start(pc); finish_check(pc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
